id_stage: RTL and testbench

// Instruction-decode stage feeding id_ex. Holds the 32x32 register file with write-back port,

---
 rtl/id_stage_if.sv | 43 ++++
 rtl/id_stage.sv | 173 +++++++++++++++++
 tb/tb_id_stage.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/id_stage_if.sv
// Bus between the instruction-decode stage and its neighbours.
// The stage itself uses the slave modport. The driver of the stage (the pipeline or a testbench)
// uses the master modport.
interface id_stage_if #(
  parameter int DATA_WIDTH = 32
);
  // From if_id / mem_wb / id_ex into decode
  logic [31:0]           instruction;
  logic                  wbRegWrite;
  logic [4:0]            wbAddress;
  logic [DATA_WIDTH-1:0] wbData;
  logic                  exMemRead;
  logic [4:0]            exAddressRt;

  // From decode towards id_ex and the PC / if_id hold logic
  logic                  hazard;
  logic                  stall;
  logic                  memToReg;
  logic                  regWrite;
  logic                  memWrite;
  logic                  memRead;
  logic                  aluSrc;
  logic                  regDst;
  logic [3:0]            aluOp;
  logic [DATA_WIDTH-1:0] immediateExtended;
  logic [4:0]            addressRs;
  logic [4:0]            addressRt;
  logic [4:0]            addressRd;
  logic [DATA_WIDTH-1:0] dataRs;
  logic [DATA_WIDTH-1:0] dataRt;

  modport master (
    output instruction, wbRegWrite, wbAddress, wbData, exMemRead, exAddressRt,
    input  hazard, stall, memToReg, regWrite, memWrite, memRead, aluSrc, regDst,
           aluOp, immediateExtended, addressRs, addressRt, addressRd, dataRs, dataRt
  );

  modport slave (
    input  instruction, wbRegWrite, wbAddress, wbData, exMemRead, exAddressRt,
    output hazard, stall, memToReg, regWrite, memWrite, memRead, aluSrc, regDst,
           aluOp, immediateExtended, addressRs, addressRt, addressRd, dataRs, dataRt
  );
endinterface

// File: rtl/id_stage.sv
// Instruction-decode stage: 32-entry register file with a write-first bypass,
// opcode/funct decode into id_ex controls, imm16 sign extension and load-use hazard detection.
// Decode and hazard outputs are pure functions of the current inputs. Only the register file
// holds state.
module id_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] REG_INIT   = {DATA_WIDTH{1'b0}}
) (
  input  logic        clk,
  input  logic        reset,
  id_stage_if.slave   bus
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  // Register read with write-first bypass; register 0 is hard-wired to zero even when
  // a (discarded) write-back to it is in flight.
  function automatic logic [DATA_WIDTH-1:0] read_port(
    input logic [4:0]            addr,
    input logic                  we,
    input logic [4:0]            wa,
    input logic [DATA_WIDTH-1:0] wd,
    input logic [DATA_WIDTH-1:0] stored
  );
    logic [DATA_WIDTH-1:0] result;
    if (addr == 5'd0) begin
      result = {DATA_WIDTH{1'b0}};
    end else if (we && (wa == addr)) begin
      result = wd;
    end else begin
      result = stored;
    end
    return result;
  endfunction

  logic [DATA_WIDTH-1:0] regs_q [32];
  logic [DATA_WIDTH-1:0] regs_d [32];

  logic [5:0] opcode_s;
  logic [5:0] funct_s;
  logic [4:0] rs_s;
  logic [4:0] rt_s;
  logic       wb_en_s;
  logic       rt_read_s;

  assign opcode_s = bus.instruction[31:26];
  assign funct_s  = bus.instruction[5:0];
  assign rs_s     = bus.instruction[25:21];
  assign rt_s     = bus.instruction[20:16];
  // Writes to register 0 never land in storage and never bypass
  assign wb_en_s  = bus.wbRegWrite && (bus.wbAddress != 5'd0);

  // Next register-file contents: one optional write-back per cycle
  always_comb begin
    regs_d = regs_q;
    if (wb_en_s) begin
      regs_d[bus.wbAddress] = bus.wbData;
    end else begin
      regs_d = regs_q;
    end
  end

  // Register-file storage; reset wins over a same-cycle write-back
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= REG_INIT;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Register-file read ports and instruction field extraction
  always_comb begin
    bus.dataRs = read_port(rs_s, wb_en_s, bus.wbAddress, bus.wbData, regs_q[rs_s]);
    bus.dataRt = read_port(rt_s, wb_en_s, bus.wbAddress, bus.wbData, regs_q[rt_s]);
    bus.addressRs = rs_s;
    bus.addressRt = rt_s;
    bus.addressRd = bus.instruction[15:11];
    bus.immediateExtended = {{(DATA_WIDTH-16){bus.instruction[15]}}, bus.instruction[15:0]};
  end

  // Control decode; unsupported opcodes and funct codes leave every control at zero
  always_comb begin
    bus.memToReg = 1'b0;
    bus.regWrite = 1'b0;
    bus.memWrite = 1'b0;
    bus.memRead  = 1'b0;
    bus.aluSrc   = 1'b0;
    bus.regDst   = 1'b0;
    bus.aluOp    = 4'b0000;
    rt_read_s    = 1'b0;
    case (opcode_s)
      OP_RTYPE: begin
        case (funct_s)
          6'b100000: begin bus.aluOp = ALU_ADD; rt_read_s = 1'b1; end
          6'b100010: begin bus.aluOp = ALU_SUB; rt_read_s = 1'b1; end
          6'b100100: begin bus.aluOp = ALU_AND; rt_read_s = 1'b1; end
          6'b100101: begin bus.aluOp = ALU_OR;  rt_read_s = 1'b1; end
          6'b101010: begin bus.aluOp = ALU_SLT; rt_read_s = 1'b1; end
          6'b100111: begin bus.aluOp = ALU_NOR; rt_read_s = 1'b1; end
          default:   begin bus.aluOp = 4'b0000; rt_read_s = 1'b0; end
        endcase
        // A valid funct is what makes this a register-writing R-type
        bus.regDst   = rt_read_s;
        bus.regWrite = rt_read_s;
      end
      OP_LW: begin
        bus.aluSrc   = 1'b1;
        bus.memRead  = 1'b1;
        bus.memToReg = 1'b1;
        bus.regWrite = 1'b1;
        bus.aluOp    = ALU_ADD;
      end
      OP_SW: begin
        bus.aluSrc   = 1'b1;
        bus.memWrite = 1'b1;
        bus.aluOp    = ALU_ADD;
        rt_read_s    = 1'b1;
      end
      OP_ADDI: begin
        bus.aluSrc   = 1'b1;
        bus.regWrite = 1'b1;
        bus.aluOp    = ALU_ADD;
      end
      OP_ANDI: begin
        bus.aluSrc   = 1'b1;
        bus.regWrite = 1'b1;
        bus.aluOp    = ALU_AND;
      end
      OP_ORI: begin
        bus.aluSrc   = 1'b1;
        bus.regWrite = 1'b1;
        bus.aluOp    = ALU_OR;
      end
      OP_SLTI: begin
        bus.aluSrc   = 1'b1;
        bus.regWrite = 1'b1;
        bus.aluOp    = ALU_SLT;
      end
      default: begin
        bus.aluOp = 4'b0000;
      end
    endcase
  end

  // Load-use detection: the load in EX targets a register this instruction reads.
  // rt only counts when the instruction really sources it (I-type ALU ops write rt).
  always_comb begin
    if (bus.exMemRead && (bus.exAddressRt != 5'd0) &&
        ((bus.exAddressRt == rs_s) || ((bus.exAddressRt == rt_s) && rt_read_s))) begin
      bus.hazard = 1'b1;
    end else begin
      bus.hazard = 1'b0;
    end
    bus.stall = bus.hazard;
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage.
module tb_id_stage;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;

  id_stage_if #(.DATA_WIDTH(32)) bus ();

  id_stage #(.DATA_WIDTH(32), .REG_INIT(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_total++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {6'b000000, rs, rt, rd, 5'b00000, funct};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Packs {memToReg,regWrite,memWrite,memRead,aluSrc,regDst,aluOp}
  function automatic logic [31:0] ctrl_vec();
    return {22'd0, bus.memToReg, bus.regWrite, bus.memWrite, bus.memRead,
            bus.aluSrc, bus.regDst, bus.aluOp};
  endfunction

  initial begin
    n_total = 0;
    n_pass  = 0;
    reset = 1'b1;
    bus.instruction = 32'h0000_0000;
    bus.wbRegWrite  = 1'b0;
    bus.wbAddress   = 5'd0;
    bus.wbData      = 32'h0000_0000;
    bus.exMemRead   = 1'b0;
    bus.exAddressRt = 5'd0;

    // 1: reset, then every register reads zero through both ports
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.instruction = itype(6'b000000, 5'(i), 5'(31 - i), 16'h0000);
      #1;
      check($sformatf("reset_rs%0d", i), bus.dataRs, 32'h0000_0000);
      check($sformatf("reset_rt%0d", 31 - i), bus.dataRt, 32'h0000_0000);
    end

    // 2: write-first bypass, then storage; register 0 stays zero
    @(negedge clk);
    bus.wbRegWrite  = 1'b1;
    bus.wbAddress   = 5'd5;
    bus.wbData      = 32'hDEAD_BEEF;
    bus.instruction = rtype(5'd5, 5'd6, 5'd7, 6'b100000);
    #1;
    check("bypass_rs5", bus.dataRs, 32'hDEAD_BEEF);
    check("bypass_rt6_untouched", bus.dataRt, 32'h0000_0000);
    @(negedge clk);
    bus.wbRegWrite  = 1'b0;
    bus.instruction = rtype(5'd6, 5'd5, 5'd7, 6'b100000);
    #1;
    check("stored_rt5", bus.dataRt, 32'hDEAD_BEEF);
    check("stored_rs6", bus.dataRs, 32'h0000_0000);
    bus.wbRegWrite  = 1'b1;
    bus.wbAddress   = 5'd0;
    bus.wbData      = 32'h0000_1234;
    bus.instruction = rtype(5'd0, 5'd0, 5'd7, 6'b100000);
    #1;
    check("reg0_bypass_blocked", bus.dataRs, 32'h0000_0000);
    @(negedge clk);
    bus.wbRegWrite = 1'b0;
    #1;
    check("reg0_storage", bus.dataRt, 32'h0000_0000);

    // 3: decode
    bus.instruction = 32'h0232_8020;  // add $16,$17,$18
    #1;
    check("add_ctrl", ctrl_vec(), {22'd0, 6'b010001, 4'b0010});
    check("add_rd", 32'(bus.addressRd), 32'd16);
    check("add_rs", 32'(bus.addressRs), 32'd17);
    check("add_rt", 32'(bus.addressRt), 32'd18);
    bus.instruction = 32'h8C48_FFFC;  // lw $8,-4($2)
    #1;
    check("lw_ctrl", ctrl_vec(), {22'd0, 6'b110110, 4'b0010});
    check("lw_imm", bus.immediateExtended, 32'hFFFF_FFFC);
    bus.instruction = rtype(5'd1, 5'd2, 5'd3, 6'b100010);
    #1;
    check("sub_ctrl", ctrl_vec(), {22'd0, 6'b010001, 4'b0110});
    bus.instruction = rtype(5'd1, 5'd2, 5'd3, 6'b100111);
    #1;
    check("nor_ctrl", ctrl_vec(), {22'd0, 6'b010001, 4'b1100});
    bus.instruction = itype(6'b101011, 5'd2, 5'd5, 16'h0010);
    #1;
    check("sw_ctrl", ctrl_vec(), {22'd0, 6'b001010, 4'b0010});
    check("sw_imm", bus.immediateExtended, 32'h0000_0010);
    bus.instruction = itype(6'b001100, 5'd2, 5'd3, 16'h7012);
    #1;
    check("andi_ctrl", ctrl_vec(), {22'd0, 6'b010010, 4'b0000});
    check("andi_imm", bus.immediateExtended, 32'h0000_7012);
    bus.instruction = itype(6'b001010, 5'd2, 5'd3, 16'h8000);
    #1;
    check("slti_ctrl", ctrl_vec(), {22'd0, 6'b010010, 4'b0111});
    check("slti_imm", bus.immediateExtended, 32'hFFFF_8000);

    // 4: load-use hazard
    bus.exMemRead   = 1'b1;
    bus.exAddressRt = 5'd8;
    bus.instruction = rtype(5'd8, 5'd10, 5'd9, 6'b100000);
    #1;
    check("haz_rs", {30'd0, bus.hazard, bus.stall}, 32'd3);
    bus.exMemRead = 1'b0;
    #1;
    check("haz_no_load", {30'd0, bus.hazard, bus.stall}, 32'd0);
    bus.exMemRead   = 1'b1;
    bus.exAddressRt = 5'd0;
    bus.instruction = rtype(5'd0, 5'd10, 5'd9, 6'b100000);
    #1;
    check("haz_reg0", {30'd0, bus.hazard, bus.stall}, 32'd0);
    bus.exAddressRt = 5'd8;
    bus.instruction = itype(6'b001000, 5'd3, 5'd8, 16'h0005);
    #1;
    check("haz_addi_rt_dest", {30'd0, bus.hazard, bus.stall}, 32'd0);
    bus.instruction = rtype(5'd3, 5'd8, 5'd9, 6'b100000);
    #1;
    check("haz_rtype_rt", {30'd0, bus.hazard, bus.stall}, 32'd3);
    bus.instruction = itype(6'b101011, 5'd3, 5'd8, 16'h0000);
    #1;
    check("haz_sw_rt", {30'd0, bus.hazard, bus.stall}, 32'd3);
    bus.instruction = rtype(5'd3, 5'd8, 5'd9, 6'b000000);
    #1;
    check("haz_nop_rt", {30'd0, bus.hazard, bus.stall}, 32'd0);
    bus.exMemRead = 1'b0;

    // 5: unknown opcode and NOP funct decode to nothing
    bus.instruction = itype(6'b111111, 5'd1, 5'd2, 16'hFFFF);
    #1;
    check("unknown_op_ctrl", ctrl_vec(), 32'd0);
    bus.instruction = rtype(5'd1, 5'd2, 5'd3, 6'b000000);
    #1;
    check("nop_ctrl", ctrl_vec(), 32'd0);

    // 6: reset discards a concurrent write-back and clears stored values
    @(negedge clk);
    reset          = 1'b1;
    bus.wbRegWrite = 1'b1;
    bus.wbAddress  = 5'd7;
    bus.wbData     = 32'h0000_0055;
    @(negedge clk);
    reset          = 1'b0;
    bus.wbRegWrite = 1'b0;
    bus.instruction = rtype(5'd7, 5'd5, 5'd3, 6'b100000);
    #1;
    check("reset_drops_wb_reg7", bus.dataRs, 32'h0000_0000);
    check("reset_clears_reg5", bus.dataRt, 32'h0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
